// File: rtl/sdram_load_pkg.sv
// Shared types and constants for the loader-to-SDRAM byte pairing writer.
package sdram_load_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drain_state_e;

  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  // Lane of a byte within a 16-bit word, taken from byte address bit 0.
  localparam logic LANE_EVEN = 1'b0;
  localparam logic LANE_ODD  = 1'b1;

  localparam int IDLE_CNT_W = 8;

  // FIFO entry is {word address, data, byte enables}.
  function automatic int entry_width(input int address_size);
    return address_size + DATA_W + BE_W;
  endfunction

endpackage

// File: rtl/loader_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit for full/empty; the parent only
// pushes when there is room (or a pop happens in the same cycle).
module loader_sync_fifo #(
  parameter int WIDTH      = 42,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/sdram_load_writer.sv
// Pairs loader byte writes into 16-bit SDRAM words with byte enables, buffers
// them in a FIFO and drains them over a req/ack handshake.
module sdram_load_writer
  import sdram_load_pkg::*;
#(
  parameter int ADDRESS_SIZE    = 24,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int FLUSH_TIMEOUT   = 63
) (
  input  logic                    clk_memory,
  input  logic                    reset,
  input  logic                    in_wr,
  input  logic [ADDRESS_SIZE:0]   in_addr,
  input  logic [7:0]              in_data,
  output logic                    sdram_req,
  input  logic                    sdram_ack,
  output logic [ADDRESS_SIZE-1:0] sdram_addr,
  output logic [15:0]             sdram_data,
  output logic [1:0]              sdram_be,
  output logic                    overflow,
  output logic                    busy
);

  localparam int ENTRY_W = entry_width(ADDRESS_SIZE);
  // The flush fires on the edge at which the idle count reaches FLUSH_TIMEOUT.
  localparam logic [IDLE_CNT_W-1:0] FLUSH_AT = IDLE_CNT_W'(FLUSH_TIMEOUT - 1);

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] word;
    logic [15:0]             data;
    logic [1:0]              be;
  } entry_t;

  logic                    pend_valid, pend_valid_next;
  logic [ADDRESS_SIZE-1:0] pend_word, pend_word_next;
  logic [15:0]             pend_data, pend_data_next;
  logic [1:0]              pend_be, pend_be_next;
  logic [IDLE_CNT_W-1:0]   idle_cnt;

  logic [ADDRESS_SIZE-1:0] in_word;
  logic                    in_lane;
  logic [15:0]             fresh_data;
  logic [1:0]              fresh_be;
  logic [15:0]             merged_data;
  logic [1:0]              merged_be;

  logic   push_req;
  entry_t push_entry;
  logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
  entry_t fifo_head;

  drain_state_e state, state_next;
  logic         load_out;

  assign in_word     = in_addr[ADDRESS_SIZE:1];
  assign in_lane     = in_addr[0];
  assign fresh_data  = (in_lane == LANE_ODD) ? {in_data, 8'h00} : {8'h00, in_data};
  assign fresh_be    = (in_lane == LANE_EVEN) ? 2'b01 : 2'b10;
  assign merged_data = pend_data | fresh_data;
  assign merged_be   = pend_be | fresh_be;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pend_valid_next = pend_valid;
    pend_word_next  = pend_word;
    pend_data_next  = pend_data;
    pend_be_next    = pend_be;
    push_req        = 1'b0;
    push_entry      = '{word: pend_word, data: pend_data, be: pend_be};

    if (in_wr) begin
      if (!pend_valid) begin
        pend_valid_next = 1'b1;
        pend_word_next  = in_word;
        pend_data_next  = fresh_data;
        pend_be_next    = fresh_be;
      end else if (in_word == pend_word && !pend_be[in_lane]) begin
        pend_data_next = merged_data;
        pend_be_next   = merged_be;
        if (merged_be == 2'b11) begin
          push_req        = 1'b1;
          push_entry      = '{word: pend_word, data: merged_data, be: merged_be};
          pend_valid_next = 1'b0;
        end
      end else begin
        // Address break or repeated lane: retire the old word as-is.
        push_req       = 1'b1;
        pend_word_next = in_word;
        pend_data_next = fresh_data;
        pend_be_next   = fresh_be;
      end
    end else if (pend_valid && idle_cnt == FLUSH_AT) begin
      push_req        = 1'b1;
      pend_valid_next = 1'b0;
    end
  end

  // A full FIFO still accepts a push when the drain pops in the same cycle.
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      pend_data  <= '0;
      pend_be    <= '0;
      idle_cnt   <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pend_valid <= pend_valid_next;
      pend_word  <= pend_word_next;
      pend_data  <= pend_data_next;
      pend_be    <= pend_be_next;
      if (in_wr)
        idle_cnt <= '0;
      else if (pend_valid && idle_cnt != '1)
        idle_cnt <= idle_cnt + 1'b1;
      if (push_req && !fifo_push)
        overflow <= 1'b1;
      busy <= pend_valid || !fifo_empty || sdram_req;
    end
  end

  loader_sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk_memory),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (push_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_out   = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          fifo_pop   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are captured once on entry to REQ and held until the ack.
  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_be   <= '0;
    end else begin
      state     <= state_next;
      sdram_req <= (state_next == ST_REQ);
      if (load_out) begin
        sdram_addr <= fifo_head.word;
        sdram_data <= fifo_head.data;
        sdram_be   <= fifo_head.be;
      end
    end
  end

endmodule
